// File: rtl/video_stream_gen.sv
// Test-pattern video source: PX_PER_CLK pixels per beat with line and
// frame strobes, horizontal and vertical blanking, frame counter.
module video_stream_gen #(
    parameter int PX_WIDTH        = 12,
    parameter int PX_PER_CLK      = 4,
    parameter int MAX_LINE_SIZE   = 4112,
    parameter int MAX_FRAME_LINES = 4096,
    localparam int WW = $clog2(MAX_LINE_SIZE + 1),
    localparam int HW = $clog2(MAX_FRAME_LINES + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           en_i,
    input  logic [WW-1:0]                  frame_width_i,
    input  logic [HW-1:0]                  frame_height_i,
    input  logic [15:0]                    h_blank_i,
    input  logic [15:0]                    v_blank_i,
    input  logic [1:0]                     pattern_sel_i,
    output logic [PX_PER_CLK*PX_WIDTH-1:0] px_data_o,
    output logic [PX_PER_CLK-1:0]          px_data_val_o,
    output logic                           line_start_o,
    output logic                           line_end_o,
    output logic                           frame_start_o,
    output logic                           frame_end_o,
    output logic [15:0]                    frame_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        HBLANK,
        VBLANK
    } state_t;

    state_t state_q, state_d;

    logic [WW-1:0] w_q, x_q, w_in;
    logic [HW-1:0] h_q, y_q, h_in;
    logic [15:0]   hb_q, vb_q, blank_q;
    logic [1:0]    pat_q;
    logic [WW:0]   lane_x;

    logic start_ok;
    logic last_beat;
    logic last_line;
    logic blank_done;
    logic frame_done;
    logic load_params;

    logic [PX_PER_CLK*PX_WIDTH-1:0] data_d;
    logic [PX_PER_CLK-1:0]          val_d;
    logic ls_d, le_d, fs_d, fe_d;

    function automatic logic [PX_WIDTH-1:0] px_value(
        input logic [WW-1:0] x,
        input logic [HW-1:0] y,
        input logic [1:0]    sel
    );
        logic [PX_WIDTH-1:0] v;
        case (sel)
            2'd0:    v = PX_WIDTH'(x);
            2'd1:    v = PX_WIDTH'(y);
            2'd2:    v = (x[3] ^ y[3]) ? '1 : '0;
            default: v = {1'b1, {(PX_WIDTH-1){1'b0}}};
        endcase
        return v;
    endfunction

    // Oversized geometry is clamped before it is latched
    assign w_in = (frame_width_i > WW'(MAX_LINE_SIZE)) ?
                  WW'(MAX_LINE_SIZE) : frame_width_i;
    assign h_in = (frame_height_i > HW'(MAX_FRAME_LINES)) ?
                  HW'(MAX_FRAME_LINES) : frame_height_i;

    assign start_ok   = en_i && (w_in != '0) && (h_in != '0);
    assign last_beat  = ({1'b0, x_q} + (WW+1)'(PX_PER_CLK)) >= {1'b0, w_q};
    assign last_line  = (y_q == h_q - HW'(1));
    assign blank_done = (blank_q == 16'd1);
    assign frame_done = (state_q == ACTIVE) && last_beat && last_line;

    assign load_params = (state_d == ACTIVE) &&
                         ((state_q == IDLE) || (state_q == VBLANK) || frame_done);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_ok) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (last_beat) begin
                    if (!last_line) begin
                        state_d = (hb_q != '0) ? HBLANK : ACTIVE;
                    end else if (vb_q != '0) begin
                        state_d = VBLANK;
                    end else begin
                        state_d = start_ok ? ACTIVE : IDLE;
                    end
                end
            end
            HBLANK: begin
                if (blank_done) state_d = ACTIVE;
            end
            VBLANK: begin
                if (blank_done) state_d = start_ok ? ACTIVE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d = '0;
        val_d  = '0;
        lane_x = '0;
        ls_d   = 1'b0;
        le_d   = 1'b0;
        fs_d   = 1'b0;
        fe_d   = 1'b0;
        if (state_q == ACTIVE) begin
            for (int j = 0; j < PX_PER_CLK; j++) begin
                lane_x = {1'b0, x_q} + (WW+1)'(j);
                if (lane_x < {1'b0, w_q}) begin
                    val_d[j] = 1'b1;
                    data_d[j*PX_WIDTH +: PX_WIDTH] =
                        px_value(lane_x[WW-1:0], y_q, pat_q);
                end
            end
            ls_d = (x_q == '0);
            le_d = last_beat;
            fs_d = (x_q == '0) && (y_q == '0);
            fe_d = frame_done;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_q           <= '0;
            h_q           <= '0;
            hb_q          <= '0;
            vb_q          <= '0;
            pat_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            blank_q       <= '0;
            px_data_o     <= '0;
            px_data_val_o <= '0;
            line_start_o  <= 1'b0;
            line_end_o    <= 1'b0;
            frame_start_o <= 1'b0;
            frame_end_o   <= 1'b0;
            frame_cnt_o   <= '0;
        end else begin
            if (load_params) begin
                w_q   <= w_in;
                h_q   <= h_in;
                hb_q  <= h_blank_i;
                vb_q  <= v_blank_i;
                pat_q <= pattern_sel_i;
                x_q   <= '0;
                y_q   <= '0;
            end else if (state_q == ACTIVE) begin
                if (last_beat) begin
                    x_q <= '0;
                    if (!last_line) y_q <= y_q + HW'(1);
                end else begin
                    x_q <= x_q + WW'(PX_PER_CLK);
                end
            end

            if ((state_q == HBLANK) || (state_q == VBLANK)) begin
                blank_q <= blank_q - 16'd1;
            end else if ((state_q == ACTIVE) && last_beat) begin
                blank_q <= last_line ? vb_q : hb_q;
            end

            px_data_o     <= data_d;
            px_data_val_o <= val_d;
            line_start_o  <= ls_d;
            line_end_o    <= le_d;
            frame_start_o <= fs_d;
            frame_end_o   <= fe_d;
            if (frame_done) frame_cnt_o <= frame_cnt_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_video_stream_gen.sv
// Self-checking bench for video_stream_gen against a frame-level
// reference model of the expected beat stream.
module tb_video_stream_gen;

    localparam int PW   = 12;
    localparam int PPC  = 4;
    localparam int MAXW = 4112;
    localparam int MAXH = 4096;
    localparam int WW   = 13;
    localparam int HW   = 13;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              en_i;
    logic [WW-1:0]     frame_width_i;
    logic [HW-1:0]     frame_height_i;
    logic [15:0]       h_blank_i;
    logic [15:0]       v_blank_i;
    logic [1:0]        pattern_sel_i;
    logic [PPC*PW-1:0] px_data_o;
    logic [PPC-1:0]    px_data_val_o;
    logic              line_start_o;
    logic              line_end_o;
    logic              frame_start_o;
    logic              frame_end_o;
    logic [15:0]       frame_cnt_o;

    always #5 clk = ~clk;

    video_stream_gen dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .en_i           (en_i),
        .frame_width_i  (frame_width_i),
        .frame_height_i (frame_height_i),
        .h_blank_i      (h_blank_i),
        .v_blank_i      (v_blank_i),
        .pattern_sel_i  (pattern_sel_i),
        .px_data_o      (px_data_o),
        .px_data_val_o  (px_data_val_o),
        .line_start_o   (line_start_o),
        .line_end_o     (line_end_o),
        .frame_start_o  (frame_start_o),
        .frame_end_o    (frame_end_o),
        .frame_cnt_o    (frame_cnt_o)
    );

    typedef struct packed {
        logic [PPC*PW-1:0] d;
        logic [PPC-1:0]    v;
        logic              ls;
        logic              le;
        logic              fs;
        logic              fe;
        logic [15:0]       fc;
    } beat_t;

    beat_t exp_q[$];
    int    model_fcnt = 0;
    int    n_checks   = 0;
    int    n_errors   = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic int px_model(int x, int y, int pat);
        case (pat)
            0:       return x % (1 << PW);
            1:       return y % (1 << PW);
            2:       return (((x / 8) % 2) != ((y / 8) % 2)) ? (1 << PW) - 1 : 0;
            default: return 1 << (PW - 1);
        endcase
    endfunction

    function automatic beat_t idle_beat();
        beat_t b;
        b    = '0;
        b.fc = 16'(model_fcnt);
        return b;
    endfunction

    function automatic int clamp(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic push_frame(int w, int h, int hb, int vb, int pat);
        int    wc = clamp(w, MAXW);
        int    hc = clamp(h, MAXH);
        int    nb = (wc + PPC - 1) / PPC;
        beat_t b;
        for (int y = 0; y < hc; y++) begin
            for (int k = 0; k < nb; k++) begin
                b = '0;
                for (int j = 0; j < PPC; j++) begin
                    if (k * PPC + j < wc) begin
                        b.v[j] = 1'b1;
                        b.d[j*PW +: PW] = PW'(px_model(k * PPC + j, y, pat));
                    end
                end
                b.ls = (k == 0);
                b.le = (k == nb - 1);
                b.fs = b.ls && (y == 0);
                b.fe = b.le && (y == hc - 1);
                if (b.fe) model_fcnt++;
                b.fc = 16'(model_fcnt);
                exp_q.push_back(b);
            end
            if (y < hc - 1) repeat (hb) exp_q.push_back(idle_beat());
        end
        repeat (vb) exp_q.push_back(idle_beat());
    endtask

    task automatic step_cmp();
        beat_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = idle_beat();
        chk("px", 64'(px_data_o), 64'(e.d));
        chk("val", 64'(px_data_val_o), 64'(e.v));
        chk("strobes",
            64'({line_start_o, line_end_o, frame_start_o, frame_end_o}),
            64'({e.ls, e.le, e.fs, e.fe}));
        chk("fcnt", 64'(frame_cnt_o), 64'(e.fc));
    endtask

    task automatic set_inputs(int w, int h, int hb, int vb, int pat);
        frame_width_i  = WW'(w);
        frame_height_i = HW'(h);
        h_blank_i      = 16'(hb);
        v_blank_i      = 16'(vb);
        pattern_sel_i  = 2'(pat);
    endtask

    task automatic scramble_inputs();
        set_inputs($urandom_range(1, 100), $urandom_range(1, 8),
                   $urandom_range(0, 5), $urandom_range(0, 5),
                   $urandom_range(0, 3));
    endtask

    // Runs nfr frames from IDLE; en_i is dropped inside the last frame and
    // inputs are scrambled mid-frame to prove they are ignored until relatch.
    task automatic run_scn(int w, int h, int hb, int vb, int pat, int nfr);
        int wc  = clamp(w, MAXW);
        int hc  = clamp(h, MAXH);
        int nb  = (wc + PPC - 1) / PPC;
        int len = hc * nb + (hc - 1) * hb + vb;
        int idx = 0;
        set_inputs(w, h, hb, vb, pat);
        en_i = 1'b1;
        exp_q.push_back(idle_beat());
        repeat (nfr) push_frame(w, h, hb, vb, pat);
        repeat (4) exp_q.push_back(idle_beat());
        while (exp_q.size() > 0) begin
            step_cmp();
            if (idx == (nfr - 1) * len) begin
                en_i = 1'b0;
                scramble_inputs();
            end else if (len >= 3 && idx < (nfr - 1) * len &&
                         idx % len == 1) begin
                scramble_inputs();
            end else if (len >= 3 && idx < (nfr - 1) * len &&
                         idx % len == len - 1) begin
                set_inputs(w, h, hb, vb, pat);
            end
            idx++;
        end
    endtask

    task automatic reset_scn();
        int idx = 0;
        set_inputs(8, 3, 2, 3, 0);
        en_i = 1'b1;
        exp_q.push_back(idle_beat());
        push_frame(8, 3, 2, 3, 0);
        while (idx <= 6) begin
            step_cmp();
            idx++;
        end
        rst_i = 1'b1;
        exp_q.delete();
        model_fcnt = 0;
        exp_q.push_back(idle_beat());
        step_cmp();
        rst_i = 1'b0;
        run_scn(8, 2, 2, 3, 0, 1);
    endtask

    initial begin
        rst_i = 1'b1;
        en_i  = 1'b0;
        set_inputs(0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        repeat (3) begin
            exp_q.push_back(idle_beat());
            step_cmp();
        end
        rst_i = 1'b0;
        step_cmp();

        run_scn(8, 2, 2, 3, 0, 2);
        run_scn(6, 2, 1, 1, 0, 1);
        run_scn(1, 3, 0, 2, 1, 1);
        run_scn(13, 4, 1, 2, 2, 1);
        reset_scn();

        set_inputs(0, 3, 1, 1, 0);
        en_i = 1'b1;
        repeat (100) begin
            exp_q.push_back(idle_beat());
            step_cmp();
        end
        en_i = 1'b0;
        step_cmp();

        run_scn(40, 20, 0, 0, 2, 2);
        run_scn(9, 2, 1, 0, 3, 3);
        run_scn(5000, 1, 0, 0, 0, 1);
        run_scn(1, 5000, 0, 1, 1, 1);

        for (int i = 0; i < 12; i++) begin
            run_scn($urandom_range(1, 70), $urandom_range(1, 6),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(1, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
